// File: rtl/misao_pkg.sv
// rtl/misao_pkg.sv - shared types and widths for the misao memory subsystem
//
// Purpose: arbiter state encoding and the core's memory bus widths, reused by
//          the core, the arbiter and their benches.
// Ports:   none (package).
package misao_pkg;

   localparam int MISAO_ADDR_W = 15;
   localparam int MISAO_DATA_W = 8;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      FORCE  = 2'd1,
      HALT   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/misao_mem_arbiter.sv
// rtl/misao_mem_arbiter.sv - core/debug arbiter for the single misao memory port
//
// Purpose: the core owns memory by default through a zero-latency pass-through;
//          debug/loader accesses use idle core cycles, a one-cycle forced slot
//          after a run of denials, or the whole bus while the core is halted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   core_rd_en/wr_en/addr/wdata   core memory request
//   core_rdata, core_hold         read data to core, core freeze
//   dbg_req/we/addr/wdata         debug request, held until dbg_gnt
//   dbg_halt                      park the core, debug owns the bus
//   dbg_gnt                       debug access performed this cycle
//   dbg_rvalid, dbg_rdata         registered read return for debug reads
//   mem_*                         memory port (combinational read data in)
module misao_mem_arbiter
   import misao_pkg::*;
#(
   parameter int ADDR_W     = MISAO_ADDR_W,
   parameter int DATA_W     = MISAO_DATA_W,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_rd_en,
   input  logic              core_wr_en,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_hold,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_halt,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_enable_read,
   output logic              mem_enable_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_data_in
);

   // A request waits at most STARVE_MAX cycles: after STARVE_MAX-1 denials the
   // next cycle is FORCE. The transition is taken on the edge where the count
   // of denials reaches STARVE_MAX-1, i.e. while the counter still reads one less.
   localparam logic [7:0] FORCE_AT = 8'(STARVE_MAX - 2);
   localparam logic [7:0] STARVE_SAT = 8'(STARVE_MAX - 1);

   arb_state_t        state_q, state_d;
   logic [7:0]        starve_q, starve_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic core_active;
   logic dbg_own;
   logic core_own;

   assign core_active = core_rd_en | core_wr_en;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= NORMAL;
         starve_q <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      if (dbg_halt) begin
         state_d = HALT;
      end else begin
         unique case (state_q)
            NORMAL: if (dbg_req && core_active && starve_q == FORCE_AT) state_d = FORCE;
            FORCE:  state_d = NORMAL;
            HALT:   state_d = NORMAL;
            default: state_d = NORMAL;
         endcase
      end
   end

   // output / ownership logic; reset forces an idle bus
   always_comb begin
      core_hold = 1'b0;
      dbg_own   = 1'b0;
      core_own  = 1'b0;
      if (!rst) begin
         unique case (state_q)
            NORMAL: begin
               core_own = core_active;
               dbg_own  = dbg_req & ~core_active;
            end
            FORCE: begin
               if (dbg_req) begin
                  core_hold = 1'b1;
                  dbg_own   = 1'b1;
               end else begin
                  core_own = core_active;
               end
            end
            HALT: begin
               core_hold = 1'b1;
               dbg_own   = dbg_req;
            end
            default: begin
               core_own = 1'b0;
            end
         endcase
      end
   end

   // Denials are only counted in NORMAL; any grant, an absent request or a
   // halt restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (dbg_halt || !dbg_req || dbg_own) begin
         starve_d = '0;
      end else if (state_q == NORMAL && starve_q != STARVE_SAT) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_comb begin
      rvalid_d = dbg_own & ~dbg_we;
      rdata_d  = rvalid_d ? mem_data_in : rdata_q;
   end

   assign dbg_gnt          = dbg_own;
   assign mem_addr         = dbg_own ? dbg_addr  : core_addr;
   assign mem_data_out     = dbg_own ? dbg_wdata : core_wdata;
   assign mem_enable_read  = dbg_own ? ~dbg_we : (core_own & core_rd_en);
   assign mem_enable_write = dbg_own ?  dbg_we : (core_own & core_wr_en);
   assign core_rdata       = mem_data_in;
   assign dbg_rvalid       = rvalid_q & ~rst;
   assign dbg_rdata        = rdata_q;

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// tb/tb_misao_mem_arbiter.sv - self-checking bench for misao_mem_arbiter
module tb_misao_mem_arbiter;

   localparam int AW = 15;
   localparam int DW = 8;
   localparam int SM = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_rd_en, core_wr_en;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic          core_hold;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_halt;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          mem_enable_read, mem_enable_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_out;
   logic [DW-1:0] mem_data_in;

   always #5 clk = ~clk;

   misao_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_hold(core_hold),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_halt(dbg_halt),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
   );

   // memory: 256 bytes aliased over the address space, combinational read
   logic [7:0] mem [0:255];
   logic       mem_inited = 1'b0;
   assign mem_data_in = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
         mem_inited <= 1'b1;
      end else if (mem_enable_write) begin
         mem[mem_addr[7:0]] <= mem_data_out;
      end
   end

   // reference model
   logic [7:0] ref_mem [0:255];
   bit         m_halted, m_force, m_rv;
   int         m_age;
   logic [7:0] m_rd;
   logic          e_hold, e_gnt, e_core, e_rd, e_wr;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic eval_chk();
      logic core_act;
      #3;
      core_act = core_rd_en | core_wr_en;
      e_hold = 1'b0; e_gnt = 1'b0; e_core = 1'b0;
      if (!rst) begin
         if (m_halted) begin
            e_hold = 1'b1; e_gnt = dbg_req;
         end else if (m_force && dbg_req) begin
            e_hold = 1'b1; e_gnt = 1'b1;
         end else begin
            e_core = core_act;
            e_gnt  = dbg_req && !core_act;
         end
      end
      e_addr  = e_gnt ? dbg_addr  : core_addr;
      e_wdata = e_gnt ? dbg_wdata : core_wdata;
      e_rd    = e_gnt ? !dbg_we : (e_core && core_rd_en);
      e_wr    = e_gnt ?  dbg_we : (e_core && core_wr_en);
      chk("core_hold",  core_hold,        e_hold);
      chk("dbg_gnt",    dbg_gnt,          e_gnt);
      chk("mem_rd_en",  mem_enable_read,  e_rd);
      chk("mem_wr_en",  mem_enable_write, e_wr);
      chk("mem_addr",   mem_addr,         e_addr);
      chk("mem_wdata",  mem_data_out,     e_wdata);
      chk("core_rdata", core_rdata,       ref_mem[e_addr[7:0]]);
      chk("dbg_rvalid", dbg_rvalid,       m_rv && !rst);
      chk("dbg_rdata",  dbg_rdata,        m_rd);
   endtask

   task automatic advance();
      logic       rd_now;
      logic [7:0] old;
      @(posedge clk);
      if (rst) begin
         m_halted = 0; m_force = 0; m_age = 0; m_rv = 0; m_rd = 8'h00;
      end else begin
         rd_now = e_gnt && !dbg_we;
         old    = ref_mem[e_addr[7:0]];
         if (e_wr) ref_mem[e_addr[7:0]] = e_wdata;
         m_rv = rd_now;
         if (rd_now) m_rd = old;
         if (dbg_halt) begin
            m_halted = 1; m_force = 0; m_age = 0;
         end else if (m_halted || m_force) begin
            m_halted = 0; m_force = 0; m_age = 0;
         end else if (dbg_req && !e_gnt) begin
            m_age++;
            m_force = (m_age == SM - 1);
         end else begin
            m_age = 0; m_force = 0;
         end
      end
      #1;
   endtask

   task automatic cycle();
      eval_chk();
      advance();
   endtask

   initial begin
      logic [7:0] prog [1:3];
      int         gk;
      int         load;
      bit         last_gnt;

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      m_halted = 0; m_force = 0; m_age = 0; m_rv = 0; m_rd = 8'h00;
      rst = 1; core_rd_en = 0; core_wr_en = 0; core_addr = '0; core_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
      @(posedge clk); #1;
      cycle();
      rst = 0;

      // idle core, debug write A5 to 0x10
      dbg_req = 1; dbg_we = 1; dbg_addr = 15'h0010; dbg_wdata = 8'hA5;
      eval_chk();
      chk("t1_gnt", dbg_gnt, 1);
      chk("t1_hold", core_hold, 0);
      advance();
      dbg_req = 0;
      eval_chk();
      chk("t1_mem", mem[8'h10], 8'hA5);
      advance();

      // starved debug read while the core reads 0x0003 continuously
      core_rd_en = 1; core_addr = 15'h0003;
      dbg_req = 1; dbg_we = 0; dbg_addr = 15'h0010;
      gk = 0;
      for (int k = 1; k <= 20; k++) begin
         eval_chk();
         if (dbg_gnt === 1'b1) begin
            gk = k;
            chk("t2_hold", core_hold, 1);
            chk("t2_addr", mem_addr, 15'h0010);
         end
         advance();
         if (gk != 0) break;
      end
      chk("t2_latency", gk, SM);
      dbg_req = 0;
      eval_chk();
      chk("t2_rvalid", dbg_rvalid, 1);
      chk("t2_rdata", dbg_rdata, 8'hA5);
      chk("t2_resume", mem_addr, 15'h0003);
      chk("t2_nohold", core_hold, 0);
      advance();

      // halt, preload three program bytes, release
      prog[1] = 8'h1F; prog[2] = 8'h4C; prog[3] = 8'h5D;
      core_addr = 15'h0001;
      dbg_halt = 1;
      cycle();
      for (int j = 1; j <= 3; j++) begin
         dbg_req = 1; dbg_we = 1; dbg_addr = 15'(j); dbg_wdata = prog[j];
         eval_chk();
         chk("t3_hold", core_hold, 1);
         chk("t3_gnt", dbg_gnt, 1);
         advance();
      end
      dbg_req = 0; dbg_halt = 0;
      eval_chk();
      chk("t3_hold_last", core_hold, 1);
      advance();
      eval_chk();
      chk("t3_release", core_hold, 0);
      chk("t3_fetch_addr", mem_addr, 15'h0001);
      chk("t3_fetch_data", core_rdata, prog[1]);
      chk("t3_mem2", mem[2], prog[2]);
      chk("t3_mem3", mem[3], prog[3]);
      advance();

      // request withdrawn in the cycle FORCE starts
      core_addr = 15'h0003;
      dbg_req = 1; dbg_we = 0; dbg_addr = 15'h0005;
      for (int k = 1; k < SM; k++) cycle();
      dbg_req = 0;
      eval_chk();
      chk("t4_hold", core_hold, 0);
      chk("t4_gnt", dbg_gnt, 0);
      chk("t4_core_rd", mem_enable_read, 1);
      chk("t4_addr", mem_addr, 15'h0003);
      advance();

      // reset one cycle after a granted read
      core_rd_en = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 15'h0010;
      eval_chk();
      chk("t5_gnt", dbg_gnt, 1);
      advance();
      dbg_req = 0; rst = 1;
      eval_chk();
      chk("t5_rvalid_rst", dbg_rvalid, 0);
      chk("t5_nowrite", mem_enable_write, 0);
      advance();
      rst = 0;
      eval_chk();
      chk("t5_rvalid", dbg_rvalid, 0);
      chk("t5_rdata", dbg_rdata, 0);
      advance();

      // simultaneous core and debug write to 0x0020
      core_wr_en = 1; core_addr = 15'h0020; core_wdata = 8'h11;
      dbg_req = 1; dbg_we = 1; dbg_addr = 15'h0020; dbg_wdata = 8'h22;
      eval_chk();
      chk("t6_gnt0", dbg_gnt, 0);
      chk("t6_wdata0", mem_data_out, 8'h11);
      advance();
      core_wr_en = 0;
      eval_chk();
      chk("t6_core_landed", mem[8'h20], 8'h11);
      chk("t6_gnt1", dbg_gnt, 1);
      advance();
      dbg_req = 0;
      eval_chk();
      chk("t6_final", mem[8'h20], 8'h22);
      advance();

      // randomized traffic
      last_gnt = 0;
      load = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) load = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 7 : 3);
         rst = ($urandom_range(0, 99) == 0);
         if (!dbg_req || last_gnt) begin
            dbg_req   = ($urandom_range(0, 2) != 0);
            dbg_we    = 1'($urandom);
            dbg_addr  = 15'($urandom_range(0, 15));
            dbg_wdata = 8'($urandom);
         end
         core_rd_en = ($urandom_range(0, 9) < load);
         core_wr_en = ($urandom_range(0, 9) == 0);
         core_addr  = 15'($urandom_range(0, 15));
         core_wdata = 8'($urandom);
         if ($urandom_range(0, 63) == 0) dbg_halt = ~dbg_halt;
         eval_chk();
         last_gnt = e_gnt || rst;
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
